// File: rtl/nn_calc_sequencer.sv
// rtl/nn_calc_sequencer.sv - address/control sequencer for a neuron-by-neuron MAC pass over one image
module nn_calc_sequencer #(
    parameter int NUM_OUT   = 10,
    parameter int NUM_PAIRS = 392
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start_calc,
    input  logic        clear_data,
    input  logic        mac_ovf,
    output logic [8:0]  pixel_address,
    output logic [11:0] weight_address,
    output logic        mac_clear,
    output logic        mac_en,
    output logic        result_we,
    output logic [3:0]  output_address,
    output logic        busy,
    output logic        done_calc,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [8:0]  IDX_LAST    = 9'(NUM_PAIRS - 1);
    localparam logic [3:0]  NEURON_LAST = 4'(NUM_OUT - 1);
    localparam logic [11:0] WBASE_STEP  = 12'(NUM_PAIRS);

    state_t      state_q;
    logic [8:0]  idx_q;
    logic [3:0]  neuron_q;
    logic [11:0] wbase_q;
    logic [8:0]  pixel_address_q;
    logic [11:0] weight_address_q;
    logic        mac_clear_q;
    logic        mac_en_q;
    logic        result_we_q;
    logic [3:0]  output_address_q;
    logic        busy_q;
    logic        done_q;
    logic        overflow_q;

    // Every output is a register updated together with the state, so each
    // output already reflects the state it belongs to in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            neuron_q         <= '0;
            wbase_q          <= '0;
            pixel_address_q  <= '0;
            weight_address_q <= '0;
            mac_clear_q      <= 1'b0;
            mac_en_q         <= 1'b0;
            result_we_q      <= 1'b0;
            output_address_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            mac_clear_q <= 1'b0;
            result_we_q <= 1'b0;
            // Read data returns one cycle after the address, so the accumulate
            // strobe is simply "an address was issued last cycle".
            mac_en_q    <= (state_q == S_RUN) && !clear_data;
            if (mac_en_q && mac_ovf) begin
                overflow_q <= 1'b1;
            end

            if (clear_data) begin
                state_q          <= S_IDLE;
                idx_q            <= '0;
                neuron_q         <= '0;
                wbase_q          <= '0;
                pixel_address_q  <= '0;
                weight_address_q <= '0;
                output_address_q <= '0;
                busy_q           <= 1'b0;
                done_q           <= 1'b0;
                overflow_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_calc) begin
                            state_q          <= S_CLR;
                            neuron_q         <= '0;
                            wbase_q          <= '0;
                            output_address_q <= '0;
                            overflow_q       <= 1'b0;
                            mac_clear_q      <= 1'b1;
                            busy_q           <= 1'b1;
                            done_q           <= 1'b0;
                        end
                    end
                    S_CLR: begin
                        state_q          <= S_RUN;
                        idx_q            <= '0;
                        pixel_address_q  <= '0;
                        weight_address_q <= wbase_q;
                    end
                    S_RUN: begin
                        if (idx_q == IDX_LAST) begin
                            state_q          <= S_DRAIN;
                            pixel_address_q  <= '0;
                            weight_address_q <= '0;
                        end else begin
                            idx_q            <= idx_q + 9'd1;
                            pixel_address_q  <= idx_q + 9'd1;
                            weight_address_q <= weight_address_q + 12'd1;
                        end
                    end
                    S_DRAIN: begin
                        state_q     <= S_STORE;
                        result_we_q <= 1'b1;
                    end
                    S_STORE: begin
                        if (neuron_q == NEURON_LAST) begin
                            state_q          <= S_DONE;
                            neuron_q         <= '0;
                            wbase_q          <= '0;
                            output_address_q <= '0;
                            busy_q           <= 1'b0;
                            done_q           <= 1'b1;
                        end else begin
                            state_q          <= S_CLR;
                            neuron_q         <= neuron_q + 4'd1;
                            output_address_q <= neuron_q + 4'd1;
                            wbase_q          <= wbase_q + WBASE_STEP;
                            mac_clear_q      <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pixel_address  = pixel_address_q;
    assign weight_address = weight_address_q;
    assign mac_clear      = mac_clear_q;
    assign mac_en         = mac_en_q;
    assign result_we      = result_we_q;
    assign output_address = output_address_q;
    assign busy           = busy_q;
    assign done_calc      = done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_nn_calc_sequencer.sv
// tb/tb_nn_calc_sequencer.sv - scoreboard bench for nn_calc_sequencer against a cycle-count model
module tb_nn_calc_sequencer;

    localparam int NO     = 10;
    localparam int NP     = 392;
    localparam int P3     = NP + 3;
    localparam int RUNLEN = NO * P3;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start_calc = 1'b0;
    logic        clear_data = 1'b0;
    logic        mac_ovf = 1'b0;
    logic [8:0]  pixel_address;
    logic [11:0] weight_address;
    logic        mac_clear;
    logic        mac_en;
    logic        result_we;
    logic [3:0]  output_address;
    logic        busy;
    logic        done_calc;
    logic        overflow;

    always #5 clk = ~clk;

    nn_calc_sequencer #(.NUM_OUT(NO), .NUM_PAIRS(NP)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start_calc     (start_calc),
        .clear_data     (clear_data),
        .mac_ovf        (mac_ovf),
        .pixel_address  (pixel_address),
        .weight_address (weight_address),
        .mac_clear      (mac_clear),
        .mac_en         (mac_en),
        .result_we      (result_we),
        .output_address (output_address),
        .busy           (busy),
        .done_calc      (done_calc),
        .overflow       (overflow)
    );

    typedef struct packed {
        logic [8:0]  pix;
        logic [11:0] wad;
        logic        mclr;
        logic        men;
        logic        rwe;
        logic [3:0]  oad;
        logic        bsy;
        logic        dn;
        logic        ovf;
    } obs_t;

    obs_t exp_q[$];
    int   oad_seq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cnt_clr = 0;
    int   cnt_men = 0;
    int   cnt_rwe = 0;

    // Model: mode 0 idle, 1 active (k = cycles since the start edge), 2 done.
    int   m_mode = 0;
    int   m_k = 0;
    logic m_ovf = 1'b0;

    function automatic obs_t model_out(input int mode, input int k, input logic ovf);
        obs_t o;
        int n, p;
        o = '0;
        if (mode == 2) begin
            o.dn  = 1'b1;
            o.ovf = ovf;
        end else if (mode == 1) begin
            n = k / P3;
            p = k % P3;
            o.bsy  = 1'b1;
            o.ovf  = ovf;
            o.oad  = 4'(n);
            o.mclr = (p == 0);
            if (p >= 1 && p <= NP) begin
                o.pix = 9'(p - 1);
                o.wad = 12'(n * NP + p - 1);
            end
            o.men = (p >= 2 && p <= NP + 1);
            o.rwe = (p == NP + 2);
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.pix  = pixel_address;
        o.wad  = weight_address;
        o.mclr = mac_clear;
        o.men  = mac_en;
        o.rwe  = result_we;
        o.oad  = output_address;
        o.bsy  = busy;
        o.dn   = done_calc;
        o.ovf  = overflow;
        return o;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        forever begin
            obs_t e;
            @(posedge clk);
            if (!n_rst) begin
                m_mode = 0; m_k = 0; m_ovf = 1'b0;
            end else if (clear_data) begin
                m_mode = 0; m_k = 0; m_ovf = 1'b0;
            end else if (m_mode != 1) begin
                if (start_calc) begin
                    m_mode = 1; m_k = 0; m_ovf = 1'b0;
                end
            end else begin
                e = model_out(m_mode, m_k, m_ovf);
                if (e.men && mac_ovf) m_ovf = 1'b1;
                m_k++;
                if (m_k == RUNLEN) m_mode = 2;
            end
            exp_q.push_back(model_out(m_mode, m_k, m_ovf));
        end
    end

    initial begin
        forever begin
            obs_t e, a;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!n_rst) e = '0;
                a = dut_obs();
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL cycle_obs t=%0t actual=%h required=%h", $time, a, e);
                end
            end
            if (mac_clear) cnt_clr++;
            if (mac_en) cnt_men++;
            if (result_we) begin
                cnt_rwe++;
                oad_seq.push_back(int'(output_address));
            end
        end
    end

    task automatic clear_counts();
        cnt_clr = 0;
        cnt_men = 0;
        cnt_rwe = 0;
        oad_seq.delete();
    endtask

    task automatic run_until_done(input int ovf_mode, output int edges);
        edges = -1;
        for (int c = 1; c <= RUNLEN + 20; c++) begin
            tick();
            start_calc = 1'b0;
            if (c == 1) begin
                chk("start_busy", busy, 1);
                chk("start_done_low", done_calc, 0);
                chk("start_ovf_cleared", overflow, 0);
            end
            case (ovf_mode)
                1:       mac_ovf = ($urandom_range(0, 63) == 0);
                2:       mac_ovf = (m_k == 4 * P3) || (m_k == 7 * P3 + 50);
                default: mac_ovf = 1'b0;
            endcase
            if (ovf_mode == 2 && m_k == 5 * P3) chk("ovf_in_clr_ignored", overflow, 0);
            if (done_calc) begin
                edges = c - 1;
                break;
            end
        end
        mac_ovf = 1'b0;
    endtask

    task automatic check_run_counts(input int edges);
        chk("done_edge", edges, RUNLEN);
        chk("mac_clear_count", cnt_clr, NO);
        chk("mac_en_count", cnt_men, NO * NP);
        chk("result_we_count", cnt_rwe, NO);
        for (int i = 0; i < NO; i++) begin
            if (i < oad_seq.size()) chk("store_order", oad_seq[i], i);
            else chk("store_missing", -1, i);
        end
    endtask

    initial begin
        int   edges;
        int   found;
        obs_t z;

        start_calc = 1'b1;
        #1;
        z = dut_obs();
        chk("reset_outputs", longint'(z), 0);
        repeat (2) @(posedge clk);
        #3;
        n_rst = 1'b1;

        clear_counts();
        run_until_done(1, edges);
        check_run_counts(edges);

        start_calc = 1'b1;
        clear_counts();
        run_until_done(2, edges);
        check_run_counts(edges);
        chk("ovf_sticky_at_done", overflow, 1);
        chk("done_addr_zero", pixel_address + weight_address + output_address, 0);

        start_calc = 1'b1;
        clear_counts();
        found = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            start_calc = 1'b0;
            if (m_mode == 1 && m_k == 2 * P3 + 101) begin
                chk("abort_idx100_pix", pixel_address, 100);
                clear_data = 1'b1;
                found = 1;
                break;
            end
        end
        chk("abort_reached", found, 1);
        tick();
        clear_data = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mac_en", mac_en, 0);
        chk("abort_result_we", result_we, 0);
        tick();
        chk("abort_no_store", cnt_rwe, 2);

        start_calc = 1'b1;
        tick();
        start_calc = 1'b0;
        chk("restart_mac_clear", mac_clear, 1);
        chk("restart_neuron0", output_address, 0);
        tick();
        chk("restart_idx0_w", weight_address, 0);
        found = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (m_k == 3 * P3 + 6) begin
                chk("addr_n3_i5_pix", pixel_address, 5);
                chk("addr_n3_i5_w", weight_address, 1181);
                tick();
                chk("addr_n3_i5_men", mac_en, 1);
            end
            if (m_k == 3 * P3 + NP + 1) begin
                found = 1;
                break;
            end
        end
        chk("drain_reached", found, 1);
        n_rst = 1'b0;
        #1;
        z = dut_obs();
        chk("async_reset_outputs", longint'(z), 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_done", done_calc, 0);

        for (int c = 0; c < 3000; c++) begin
            tick();
            start_calc = ($urandom_range(0, 29) == 0);
            clear_data = ($urandom_range(0, 299) == 0);
            mac_ovf    = ($urandom_range(0, 39) == 0);
        end
        start_calc = 1'b0;
        clear_data = 1'b0;
        mac_ovf    = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_calc_sequencer.md
NN_CALC_SEQUENCER -- requirements
Module: nn_calc_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 10, number of output neurons sequenced.
REQ-002 SHALL have parameter NUM_PAIRS, default 392, pixel-pair words per image (784 pixels, two per word).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_calc  input  1  start request, level, sampled only in IDLE and DONE.
REQ-006 SHALL have port clear_data  input  1  synchronous abort/clear, priority over start_calc.
REQ-007 SHALL have port mac_ovf  input  1  overflow flag from external MAC, valid while mac_en=1.
REQ-008 SHALL have port pixel_address  output  9  pixel-pair word read address.
REQ-009 SHALL have port weight_address  output  12  weight word read address.
REQ-010 SHALL have port mac_clear  output  1  zero MAC accumulator this cycle.
REQ-011 SHALL have port mac_en  output  1  accumulate current memory read data this cycle.
REQ-012 SHALL have port result_we  output  1  write MAC result to result register at output_address.
REQ-013 SHALL have port output_address  output  4  current neuron index 0..NUM_OUT-1.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-015 SHALL have port done_calc  output  1  high in DONE only.
REQ-016 SHALL have port overflow  output  1  sticky MAC overflow for current run.

Function
REQ-017 SHALL implement states IDLE, CLR, RUN, DRAIN, STORE, DONE, registered.
REQ-018 IDLE: start_calc=1 and clear_data=0 -> CLR, neuron=0, overflow cleared.
REQ-019 CLR: mac_clear=1 one cycle, idx=0 -> RUN.
REQ-020 RUN: pixel_address=idx, weight_address=neuron*NUM_PAIRS+idx; idx increments each cycle; idx=NUM_PAIRS-1 -> DRAIN.
REQ-021 Memories have 1-cycle read latency: mac_en SHALL be the address-issue qualifier delayed one cycle, so mac_en=0 first RUN cycle, 1 for remaining RUN cycles and the DRAIN cycle (exactly NUM_PAIRS pulses per neuron).
REQ-022 DRAIN: one cycle, no new address -> STORE.
REQ-023 STORE: result_we=1, output_address=neuron, one cycle; neuron=NUM_OUT-1 -> DONE, else neuron+1 -> CLR.
REQ-024 DONE: done_calc=1 held; start_calc=1 -> CLR with neuron=0 and overflow cleared; otherwise hold.
REQ-025 Per neuron SHALL take NUM_PAIRS+3 cycles; done_calc SHALL rise NUM_OUT*(NUM_PAIRS+3) = 3950 edges after edge sampling start_calc.
REQ-026 weight_address SHALL never exceed NUM_OUT*NUM_PAIRS-1 (3919); no wrap within a run.
REQ-027 overflow SHALL set when mac_en=1 and mac_ovf=1; cleared only by start acceptance, clear_data, or reset; mac_ovf ignored when mac_en=0.
REQ-028 clear_data=1 in any state -> IDLE next edge, idx/neuron/overflow zeroed, mac_en/result_we/mac_clear low next cycle; in-flight neuron not stored.
REQ-029 start_calc held high during busy SHALL be ignored; start_calc and clear_data both high -> clear wins.
REQ-030 pixel_address, weight_address, output_address SHALL be 0 in IDLE and DONE.

Reset
REQ-031 n_rst=0 SHALL immediately force IDLE, idx=0, neuron=0, all outputs 0, regardless of clock.
REQ-032 Reset deasserting with start_calc=1 SHALL start on first active edge, not during reset.

Verification
REQ-033 Full run: pulse start_calc 1 cycle -> 10 mac_clear, 3920 mac_en, 10 result_we with output_address 0..9 in order, done_calc high at edge 3950.
REQ-034 Address check: neuron 3, idx 5 -> pixel_address=5, weight_address=1181; mac_en high following cycle.
REQ-035 Overflow: mac_ovf=1 one cycle while mac_en=1 in neuron 7 -> overflow=1 through DONE; mac_ovf=1 during CLR -> no set; restart -> overflow=0.
REQ-036 Abort: clear_data=1 in RUN neuron 2 idx 100 -> IDLE next cycle, no result_we, busy=0; new start -> neuron 0 idx 0.
REQ-037 Reset mid-run: n_rst low between edges in DRAIN -> all outputs 0 immediately, IDLE after release.
REQ-038 Restart from DONE: start_calc=1 while done_calc=1 -> CLR next edge, done_calc=0, second run identical timing.
